// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: frame-timed transmitter and a 16x oversampling
// receiver that share one clock domain.
module uart_transceiver #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       wr_en,
    output logic       Tx,
    output logic       Tx_busy,
    input  logic       Rx,
    output logic       ready,
    input  logic       ready_clr,
    output logic [7:0] data_out
);

    localparam int TX_DIV = CLK_FREQ / BAUD;
    localparam int RX_DIV = CLK_FREQ / (16 * BAUD);
    localparam int TXW    = $clog2(TX_DIV + 1);
    localparam int RXW    = $clog2(RX_DIV + 1);
    localparam logic [TXW-1:0] TX_LAST = TXW'(TX_DIV - 1);
    localparam logic [RXW-1:0] RX_LAST = RXW'(RX_DIV - 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    tx_state_t      r_tx_state;
    tx_state_t      w_tx_next;
    logic [TXW-1:0] r_tx_cnt;
    logic [TXW-1:0] w_tx_cnt_nx;
    logic [2:0]     r_tx_bit;
    logic [2:0]     w_tx_bit_nx;
    logic [7:0]     r_tx_shift;
    logic [7:0]     w_tx_shift_nx;
    logic           w_tx_end;

    assign w_tx_end = (r_tx_cnt == TX_LAST);

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
        end else begin
            r_tx_state <= w_tx_next;
            r_tx_cnt   <= w_tx_cnt_nx;
            r_tx_bit   <= w_tx_bit_nx;
            r_tx_shift <= w_tx_shift_nx;
        end
    end

    always_comb begin
        w_tx_next     = r_tx_state;
        w_tx_cnt_nx   = r_tx_cnt + TXW'(1);
        w_tx_bit_nx   = r_tx_bit;
        w_tx_shift_nx = r_tx_shift;
        unique case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_nx = '0;
                if (wr_en) begin
                    w_tx_shift_nx = data_in;
                    w_tx_bit_nx   = '0;
                    w_tx_next     = TX_START;
                end
            end
            TX_START: begin
                if (w_tx_end) begin
                    w_tx_cnt_nx = '0;
                    w_tx_next   = TX_DATA;
                end
            end
            TX_DATA: begin
                if (w_tx_end) begin
                    w_tx_cnt_nx   = '0;
                    w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
                    w_tx_bit_nx   = r_tx_bit + 3'd1;
                    if (r_tx_bit == 3'd7)
                        w_tx_next = TX_STOP;
                end
            end
            TX_STOP: begin
                if (w_tx_end) begin
                    w_tx_cnt_nx = '0;
                    w_tx_next   = TX_IDLE;
                end
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    // Line level decodes straight from registered state so reset forces idle-high at once
    always_comb begin
        Tx = 1'b1;
        unique case (r_tx_state)
            TX_IDLE:  Tx = 1'b1;
            TX_START: Tx = 1'b0;
            TX_DATA:  Tx = r_tx_shift[0];
            TX_STOP:  Tx = 1'b1;
            default:  Tx = 1'b1;
        endcase
    end

    assign Tx_busy = (r_tx_state != TX_IDLE);

    logic           r_rx_meta;
    logic           r_rx_sync;
    logic [RXW-1:0] r_rx_div;
    logic           w_rx_tick;
    rx_state_t      r_rx_state;
    rx_state_t      w_rx_next;
    logic [3:0]     r_rx_tcnt;
    logic [3:0]     w_rx_tcnt_nx;
    logic [2:0]     r_rx_bit;
    logic [2:0]     w_rx_bit_nx;
    logic [7:0]     r_rx_shift;
    logic [7:0]     w_rx_shift_nx;
    logic           w_rx_load;
    logic           r_ready;
    logic [7:0]     r_data_out;

    assign w_rx_tick = (r_rx_div == RX_LAST);

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_div  <= '0;
        end else begin
            r_rx_meta <= Rx;
            r_rx_sync <= r_rx_meta;
            r_rx_div  <= w_rx_tick ? '0 : r_rx_div + RXW'(1);
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= RX_IDLE;
            r_rx_tcnt  <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_state <= w_rx_next;
            r_rx_tcnt  <= w_rx_tcnt_nx;
            r_rx_bit   <= w_rx_bit_nx;
            r_rx_shift <= w_rx_shift_nx;
        end
    end

    always_comb begin
        w_rx_next     = r_rx_state;
        w_rx_tcnt_nx  = r_rx_tcnt;
        w_rx_bit_nx   = r_rx_bit;
        w_rx_shift_nx = r_rx_shift;
        w_rx_load     = 1'b0;
        unique case (r_rx_state)
            RX_IDLE: begin
                if (!r_rx_sync) begin
                    w_rx_tcnt_nx = '0;
                    w_rx_next    = RX_START;
                end
            end
            RX_START: begin
                if (w_rx_tick) begin
                    if (r_rx_tcnt == 4'd7) begin
                        w_rx_tcnt_nx = '0;
                        w_rx_bit_nx  = '0;
                        w_rx_next    = r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        w_rx_tcnt_nx = r_rx_tcnt + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (w_rx_tick) begin
                    if (r_rx_tcnt == 4'd15) begin
                        w_rx_tcnt_nx  = '0;
                        w_rx_shift_nx = {r_rx_sync, r_rx_shift[7:1]};
                        w_rx_bit_nx   = r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7)
                            w_rx_next = RX_STOP;
                    end else begin
                        w_rx_tcnt_nx = r_rx_tcnt + 4'd1;
                    end
                end
            end
            RX_STOP: begin
                if (w_rx_tick) begin
                    if (r_rx_tcnt == 4'd15) begin
                        w_rx_tcnt_nx = '0;
                        w_rx_load    = r_rx_sync;
                        w_rx_next    = RX_IDLE;
                    end else begin
                        w_rx_tcnt_nx = r_rx_tcnt + 4'd1;
                    end
                end
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    // A completing byte outranks a simultaneous clear
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_ready    <= 1'b0;
            r_data_out <= 8'h00;
        end else begin
            if (w_rx_load) begin
                r_ready    <= 1'b1;
                r_data_out <= r_rx_shift;
            end else if (ready_clr) begin
                r_ready    <= 1'b0;
            end
        end
    end

    assign ready    = r_ready;
    assign data_out = r_data_out;

endmodule

// File: tb/tb_uart_transceiver.sv
// Scoreboard bench for uart_transceiver: loopback frames, line-level
// timing probes, receiver error cases, overrun and mid-frame reset.
module tb_uart_transceiver;

    logic       clk_50m = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       wr_en = 1'b0;
    logic       Tx;
    logic       Tx_busy;
    logic       Rx;
    logic       ready;
    logic       ready_clr = 1'b0;
    logic [7:0] data_out;

    logic       loop = 1'b1;
    logic       rx_drv = 1'b1;
    logic [7:0] q[$];
    logic [7:0] last_rx = 8'h00;
    int         n_vec = 0;
    int         n_err = 0;

    assign Rx = loop ? Tx : rx_drv;

    always #10 clk_50m = ~clk_50m;

    uart_transceiver dut (
        .clk_50m   (clk_50m),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .wr_en     (wr_en),
        .Tx        (Tx),
        .Tx_busy   (Tx_busy),
        .Rx        (Rx),
        .ready     (ready),
        .ready_clr (ready_clr),
        .data_out  (data_out)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Tx_busy && n < 6000) begin
            @(negedge clk_50m);
            n++;
        end
        if (n >= 6000)
            check("idle_timeout", Tx_busy, 0);
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!ready && n < 6000) begin
            @(negedge clk_50m);
            n++;
        end
        if (!ready)
            check("rx_timeout", ready, 1);
        ok = ready;
    endtask

    task automatic rx_pop(input string tag);
        logic [7:0] exp;
        if (q.size() == 0) begin
            check({tag, "_queue"}, q.size(), 1);
        end else begin
            exp = q.pop_front();
            check(tag, data_out, exp);
            last_rx = exp;
        end
    endtask

    task automatic clr_ready();
        ready_clr = 1'b1;
        @(negedge clk_50m);
        ready_clr = 1'b0;
        check("ready_clr", ready, 0);
    endtask

    task automatic tx_frame(input logic [7:0] b, input bit inj);
        logic [9:0] fr;
        int n;
        int lowrun;
        int tz;
        bit inrun;
        fr = {1'b1, b, 1'b0};
        tz = 1;
        for (int i = 0; i < 8 && !b[i]; i++)
            tz++;
        q.push_back(b);
        wait_idle();
        data_in = b;
        wr_en = 1'b1;
        @(negedge clk_50m);
        wr_en = 1'b0;
        check("tx_busy_rise", Tx_busy, 1);
        n = 0;
        lowrun = 0;
        inrun = 1'b1;
        while (Tx_busy && n < 5000) begin
            wr_en = inj && (n == 100);
            if (inj && n == 100)
                data_in = 8'h3C;
            if (n % 434 == 217 && n < 4340)
                check("tx_bit", Tx, fr[n / 434]);
            if (inrun && !Tx)
                lowrun++;
            else
                inrun = 1'b0;
            n++;
            @(negedge clk_50m);
        end
        wr_en = 1'b0;
        check("tx_busy_len", n, 4340);
        check("tx_start_len", lowrun, 434 * tz);
    endtask

    task automatic rx_drive(input logic [7:0] b, input bit stop);
        loop = 1'b0;
        rx_drv = 1'b0;
        repeat (434) @(negedge clk_50m);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (434) @(negedge clk_50m);
        end
        rx_drv = stop;
        repeat (stop ? 434 : 300) @(negedge clk_50m);
        rx_drv = 1'b1;
    endtask

    initial begin
        bit ok;
        int n;

        repeat (5) @(negedge clk_50m);
        check("rst_tx", Tx, 1);
        check("rst_busy", Tx_busy, 0);
        check("rst_ready", ready, 0);
        check("rst_dout", data_out, 8'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_50m);

        for (int i = 0; i < 3; i++) begin
            tx_frame(8'(i), 1'b0);
            wait_ready(ok);
            if (ok) begin
                rx_pop("loop_data");
                clr_ready();
            end
        end

        tx_frame(8'hA5, 1'b0);
        wait_ready(ok);
        if (ok) begin
            rx_pop("a5_data");
            clr_ready();
        end

        tx_frame(8'h11, 1'b1);
        wait_ready(ok);
        if (ok) begin
            rx_pop("drop_data");
            clr_ready();
        end
        check("drop_busy", Tx_busy, 0);
        repeat (600) @(negedge clk_50m);
        check("drop_ready", ready, 0);

        loop = 1'b0;
        rx_drv = 1'b0;
        repeat (100) @(negedge clk_50m);
        rx_drv = 1'b1;
        repeat (1000) @(negedge clk_50m);
        check("false_start", ready, 0);

        rx_drive(8'h5A, 1'b0);
        repeat (1000) @(negedge clk_50m);
        check("frame_err_ready", ready, 0);
        check("frame_err_dout", data_out, last_rx);

        q.push_back(8'hC3);
        rx_drive(8'hC3, 1'b1);
        wait_ready(ok);
        if (ok) begin
            rx_pop("manual_data");
            clr_ready();
        end
        loop = 1'b1;
        repeat (20) @(negedge clk_50m);

        tx_frame(8'h55, 1'b0);
        wait_ready(ok);
        if (ok)
            rx_pop("ovr_first");
        tx_frame(8'h66, 1'b0);
        n = 0;
        while (data_out == 8'h55 && n < 6000) begin
            @(negedge clk_50m);
            n++;
        end
        rx_pop("ovr_data");
        check("ovr_ready", ready, 1);

        ready_clr = 1'b1;
        @(negedge clk_50m);
        check("clr_hold", ready, 0);
        q.push_back(8'h33);
        wait_idle();
        data_in = 8'h33;
        wr_en = 1'b1;
        @(negedge clk_50m);
        wr_en = 1'b0;
        n = 0;
        while (!ready && n < 6000) begin
            @(negedge clk_50m);
            n++;
        end
        check("set_wins", ready, 1);
        rx_pop("set_wins_data");
        @(negedge clk_50m);
        ready_clr = 1'b0;
        check("clr_after_set", ready, 0);
        wait_idle();
        repeat (20) @(negedge clk_50m);

        data_in = 8'h99;
        wr_en = 1'b1;
        @(negedge clk_50m);
        wr_en = 1'b0;
        repeat (1000) @(negedge clk_50m);
        #3 rst_n = 1'b0;
        #1;
        check("arst_tx", Tx, 1);
        check("arst_busy", Tx_busy, 0);
        check("arst_dout", data_out, 8'h00);
        last_rx = 8'h00;
        repeat (3) @(negedge clk_50m);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_50m);
        check("post_rst_ready", ready, 0);

        tx_frame(8'h7E, 1'b0);
        wait_ready(ok);
        if (ok) begin
            rx_pop("post_rst_data");
            clr_ready();
        end
        check("queue_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
